// File: rtl/wb_csr_pkg.sv
// Register offsets, STATUS/CTRL bit positions and reset values for wb_csr_fifo.
package wb_csr_pkg;

    // Register offsets within the low word-address window
    typedef enum logic [1:0] {
        CSR_SCRATCH = 2'd0,
        CSR_STATUS  = 2'd1,
        CSR_PUSH    = 2'd2,
        CSR_CTRL    = 2'd3
    } csr_addr_e;

    // STATUS fields
    localparam int unsigned STATUS_LEVEL_LSB = 0;
    localparam int unsigned STATUS_LEVEL_W   = 8;
    localparam int unsigned STATUS_EMPTY_BIT = 8;
    localparam int unsigned STATUS_FULL_BIT  = 9;
    localparam int unsigned STATUS_OVF_BIT   = 10;

    // Overflow clear is only honoured when this byte lane is selected
    localparam int unsigned STATUS_OVF_CLR_LANE = 1;

    // CTRL fields (both live in byte lane 0)
    localparam int unsigned CTRL_FLUSH_BIT  = 0;
    localparam int unsigned CTRL_OUT_EN_BIT = 1;
    localparam int unsigned CTRL_LANE       = 0;

    // Reset values
    localparam logic [31:0] SCRATCH_RESET    = 32'h0000_0000;
    localparam logic        OUT_ENABLE_RESET = 1'b0;
    localparam logic        OVERFLOW_RESET   = 1'b0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fall-through head, flush and level count.
module sync_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH):0]       level,
    output logic [WIDTH-1:0]             head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);
    assign head  = mem[rd_ptr];

    // Flush overrides both sides; a full FIFO still accepts a push alongside a pop
    assign pop_ok  = pop  & ~flush & ~empty;
    assign push_ok = push & ~flush & (~full | pop_ok);

    // Pointer and level bookkeeping; pointers wrap naturally at DEPTH (power of two)
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage write; contents are not reset
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/wb_csr_fifo.sv
// Wishbone CSR block: scratch/status/push/ctrl registers feeding a push FIFO.
module wb_csr_fifo
    import wb_csr_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 14,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned SEL_WIDTH     = 4,
    parameter int unsigned FIFO_DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_CYC,
    input  logic                     wb_STB,
    input  logic                     wb_WE,
    input  logic [ADDRESS_WIDTH-1:0] wb_ADR,
    input  logic [DATA_WIDTH-1:0]    wb_DAT_MOSI,
    input  logic [SEL_WIDTH-1:0]     wb_SEL,
    output logic                     wb_ACK,
    output logic [DATA_WIDTH-1:0]    wb_DAT_MISO,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [SEL_WIDTH-1:0]     out_sel
);

    localparam int unsigned LANE_W  = DATA_WIDTH / SEL_WIDTH;
    localparam int unsigned ENTRY_W = DATA_WIDTH + SEL_WIDTH;
    localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] scratch;
    logic                  out_enable;
    logic                  overflow;

    logic                  access;
    logic                  in_window;
    csr_addr_e             reg_sel;
    logic                  wr_scratch;
    logic                  wr_status;
    logic                  wr_ctrl;
    logic                  push_req;
    logic                  pop_req;
    logic                  flush_req;
    logic                  ovf_clear;
    logic [DATA_WIDTH-1:0] rdata;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [LVL_W-1:0]      fifo_level;
    logic [ENTRY_W-1:0]    fifo_head;

    // A transfer is acted on in exactly the cycle its ACK is being generated
    assign access    = wb_CYC & wb_STB & ~wb_ACK;
    assign in_window = (wb_ADR[ADDRESS_WIDTH-1:2] == '0);
    assign reg_sel   = csr_addr_e'(wb_ADR[1:0]);

    assign wr_scratch = access & wb_WE & in_window & (reg_sel == CSR_SCRATCH);
    assign wr_status  = access & wb_WE & in_window & (reg_sel == CSR_STATUS);
    assign wr_ctrl    = access & wb_WE & in_window & (reg_sel == CSR_CTRL) & wb_SEL[CTRL_LANE];
    assign push_req   = access & wb_WE & in_window & (reg_sel == CSR_PUSH) & (wb_SEL != '0);
    assign flush_req  = wr_ctrl & wb_DAT_MOSI[CTRL_FLUSH_BIT];
    assign ovf_clear  = wr_status & wb_SEL[STATUS_OVF_CLR_LANE] & wb_DAT_MOSI[STATUS_OVF_BIT];

    assign out_valid = ~fifo_empty & out_enable;
    assign pop_req   = out_valid & out_ready;
    assign out_data  = fifo_head[ENTRY_W-1:SEL_WIDTH];
    assign out_sel   = fifo_head[SEL_WIDTH-1:0];

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data ({wb_DAT_MOSI, wb_SEL}),
        .pop       (pop_req),
        .flush     (flush_req),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level),
        .head      (fifo_head)
    );

    // Read data mux; out-of-window and write-only registers read as zero
    always_comb begin
        rdata = '0;
        if (in_window) begin
            case (reg_sel)
                CSR_SCRATCH: rdata = scratch;
                CSR_STATUS: begin
                    rdata[STATUS_LEVEL_LSB +: STATUS_LEVEL_W] = STATUS_LEVEL_W'(fifo_level);
                    rdata[STATUS_EMPTY_BIT] = fifo_empty;
                    rdata[STATUS_FULL_BIT]  = fifo_full;
                    rdata[STATUS_OVF_BIT]   = overflow;
                end
                CSR_CTRL:    rdata[CTRL_OUT_EN_BIT] = out_enable;
                default:     rdata = '0;
            endcase
        end
    end

    // Bus handshake: single-cycle ACK pulse and read data valid only alongside it
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_ACK      <= 1'b0;
            wb_DAT_MISO <= '0;
        end else begin
            wb_ACK      <= access;
            wb_DAT_MISO <= (access & ~wb_WE) ? rdata : '0;
        end
    end

    // Scratch register with per-lane write enables
    always_ff @(posedge clk) begin
        if (reset) begin
            scratch <= DATA_WIDTH'(SCRATCH_RESET);
        end else if (wr_scratch) begin
            for (int i = 0; i < int'(SEL_WIDTH); i++) begin
                if (wb_SEL[i]) scratch[i*LANE_W +: LANE_W] <= wb_DAT_MOSI[i*LANE_W +: LANE_W];
            end
        end
    end

    // Output enable and sticky overflow; a push dropped for lack of space sets overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            out_enable <= OUT_ENABLE_RESET;
            overflow   <= OVERFLOW_RESET;
        end else begin
            if (wr_ctrl) out_enable <= wb_DAT_MOSI[CTRL_OUT_EN_BIT];
            if (push_req & fifo_full & ~pop_req & ~flush_req) overflow <= 1'b1;
            else if (ovf_clear) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_csr_fifo.sv
// Directed bench for wb_csr_fifo: bus handshake, register map and FIFO behaviour.
module tb_wb_csr_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_CYC;
    logic        wb_STB;
    logic        wb_WE;
    logic [13:0] wb_ADR;
    logic [31:0] wb_DAT_MOSI;
    logic [3:0]  wb_SEL;
    logic        wb_ACK;
    logic [31:0] wb_DAT_MISO;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_sel;

    int checks = 0;
    int errors = 0;

    logic [31:0] pop_data [$];
    logic [3:0]  pop_sel  [$];

    wb_csr_fifo #(
        .ADDRESS_WIDTH (14),
        .DATA_WIDTH    (32),
        .SEL_WIDTH     (4),
        .FIFO_DEPTH    (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wb_CYC      (wb_CYC),
        .wb_STB      (wb_STB),
        .wb_WE       (wb_WE),
        .wb_ADR      (wb_ADR),
        .wb_DAT_MOSI (wb_DAT_MOSI),
        .wb_SEL      (wb_SEL),
        .wb_ACK      (wb_ACK),
        .wb_DAT_MISO (wb_DAT_MISO),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sel     (out_sel)
    );

    always #5 clk = ~clk;

    // Record every word the consumer accepts
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            pop_data.push_back(out_data);
            pop_sel.push_back(out_sel);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One bus transfer; optionally raise out_ready for exactly the ACK cycle
    task automatic xfer(input logic we, input logic [13:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input bit pulse_ready,
                        output logic [31:0] rdata, output int lat,
                        output logic ack_after, output logic [31:0] dat_after,
                        output logic valid_at_ack);
        wb_CYC = 1'b1;
        wb_STB = 1'b1;
        wb_WE  = we;
        wb_ADR = adr;
        wb_DAT_MOSI = dat;
        wb_SEL = we ? sel : 4'h0;
        if (pulse_ready) out_ready = 1'b1;
        lat = 0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            if (wb_ACK) begin
                lat = i;
                break;
            end
        end
        rdata = wb_DAT_MISO;
        valid_at_ack = out_valid;
        wb_CYC = 1'b0;
        wb_STB = 1'b0;
        wb_WE  = 1'b0;
        wb_SEL = 4'h0;
        if (pulse_ready) out_ready = 1'b0;
        @(posedge clk); #1;
        ack_after = wb_ACK;
        dat_after = wb_DAT_MISO;
    endtask

    task automatic wr(input string tag, input logic [13:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel);
        logic [31:0] rd_d, d_after;
        int          lat;
        logic        a_after, v;
        xfer(1'b1, adr, dat, sel, 1'b0, rd_d, lat, a_after, d_after, v);
        check({tag, "_ack_lat"}, 32'(lat), 32'd1);
        check({tag, "_wdat"}, rd_d, 32'h0);
    endtask

    task automatic rd(input string tag, input logic [13:0] adr, input logic [31:0] exp);
        logic [31:0] rd_d, d_after;
        int          lat;
        logic        a_after, v;
        xfer(1'b0, adr, 32'h0, 4'h0, 1'b0, rd_d, lat, a_after, d_after, v);
        check({tag, "_ack_lat"}, 32'(lat), 32'd1);
        check(tag, rd_d, exp);
    endtask

    initial begin
        logic [31:0] rd_d, d_after;
        int          lat, base, n;
        logic        a_after, v_ack;

        // Reset asserted while a transfer is being requested: no ACK may appear
        reset = 1'b1;
        wb_CYC = 1'b1; wb_STB = 1'b1; wb_WE = 1'b0; wb_ADR = 14'h0;
        wb_DAT_MOSI = 32'h0; wb_SEL = 4'h0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", 32'(wb_ACK), 32'd0);
        check("reset_miso", wb_DAT_MISO, 32'h0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        wb_CYC = 1'b0; wb_STB = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;

        rd("reset_status", 14'h1, 32'h100);
        rd("reset_scratch", 14'h0, 32'h0);
        rd("reset_ctrl", 14'h3, 32'h0);

        // Lane-masked scratch write, ACK timing
        xfer(1'b1, 14'h0, 32'hDEADBEEF, 4'b0101, 1'b0, rd_d, lat, a_after, d_after, v_ack);
        check("scr_wr_lat", 32'(lat), 32'd1);
        check("scr_wr_ack_pulse", 32'(a_after), 32'd0);
        xfer(1'b0, 14'h0, 32'h0, 4'h0, 1'b0, rd_d, lat, a_after, d_after, v_ack);
        check("scr_rd_lat", 32'(lat), 32'd1);
        check("scr_rd_data", rd_d, 32'h00AD00EF);
        check("scr_rd_ack_pulse", 32'(a_after), 32'd0);
        check("scr_rd_miso_idle", d_after, 32'h0);

        // Out-of-window address: ACKed, reads zero, write ignored
        rd("oow_read", 14'h0010, 32'h0);
        wr("oow_write", 14'h0010, 32'h12345678, 4'hF);
        rd("oow_scratch_kept", 14'h0, 32'h00AD00EF);

        // Fill past capacity with the consumer stalled
        for (int i = 1; i <= 9; i++) wr("fill_push", 14'h2, 32'(i), 4'hF);
        rd("full_status", 14'h1, 32'h608);
        check("full_out_valid_disabled", 32'(out_valid), 32'd0);
        check("full_head_data", out_data, 32'h1);
        check("full_head_sel", 32'(out_sel), 32'hF);
        rd("push_reads_zero", 14'h2, 32'h0);
        wr("ovf_clear", 14'h1, 32'h400, 4'b0010);
        rd("ovf_cleared_status", 14'h1, 32'h208);
        wr("push_sel0", 14'h2, 32'hBAD0BAD0, 4'h0);
        rd("push_sel0_status", 14'h1, 32'h208);

        // Full FIFO: push accepted when a pop happens in the same cycle
        wr("enable_out", 14'h3, 32'h2, 4'hF);
        rd("ctrl_readback", 14'h3, 32'h2);
        check("enabled_out_valid", 32'(out_valid), 32'd1);
        base = pop_data.size();
        xfer(1'b1, 14'h2, 32'h33, 4'hF, 1'b1, rd_d, lat, a_after, d_after, v_ack);
        check("full_pushpop_lat", 32'(lat), 32'd1);
        rd("full_pushpop_status", 14'h1, 32'h208);
        out_ready = 1'b1;
        for (int i = 0; i < 30 && out_valid; i++) @(posedge clk);
        #1;
        n = pop_data.size() - base;
        check("drain_count", 32'(n), 32'd9);
        if (n == 9) begin
            check("drain_first", pop_data[base], 32'h1);
            check("drain_eighth", pop_data[base+7], 32'h8);
            check("drain_last", pop_data[base+8], 32'h33);
            check("drain_last_sel", 32'(pop_sel[base+8]), 32'hF);
        end
        rd("drained_status", 14'h1, 32'h100);

        // Fall-through delivery with the consumer ready
        base = pop_data.size();
        xfer(1'b1, 14'h2, 32'h11, 4'hF, 1'b0, rd_d, lat, a_after, d_after, v_ack);
        check("ft_valid_next_cycle", 32'(v_ack), 32'd1);
        wr("ft_push2", 14'h2, 32'h22, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        n = pop_data.size() - base;
        check("ft_count", 32'(n), 32'd2);
        if (n == 2) begin
            check("ft_data0", pop_data[base], 32'h11);
            check("ft_sel0", 32'(pop_sel[base]), 32'hF);
            check("ft_data1", pop_data[base+1], 32'h22);
            check("ft_sel1", 32'(pop_sel[base+1]), 32'hF);
        end
        rd("ft_status", 14'h1, 32'h100);

        // Flush wins over a concurrent pop
        out_ready = 1'b0;
        wr("fl_push_a", 14'h2, 32'hA, 4'hF);
        wr("fl_push_b", 14'h2, 32'hB, 4'hF);
        wr("fl_push_c", 14'h2, 32'hC, 4'hF);
        rd("fl_pre_status", 14'h1, 32'h003);
        xfer(1'b1, 14'h3, 32'h1, 4'hF, 1'b1, rd_d, lat, a_after, d_after, v_ack);
        check("fl_lat", 32'(lat), 32'd1);
        check("fl_out_valid_next", 32'(v_ack), 32'd0);
        rd("fl_status", 14'h1, 32'h100);
        rd("fl_ctrl_reads", 14'h3, 32'h0);
        check("fl_out_valid", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the bench cannot hang
    initial begin
        #200000;
        $display("FAIL timeout reached observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
